// File: rtl/dpram_be_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dpram_be_arbiter_pkg: shared types for the DPRAM arbiter slice |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package dpram_be_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/DPRAM_BE.sv
`default_nettype none
// +----------------------------------------------------------------+
// | DPRAM_BE: simple dual-port RAM, byte-enabled write, reg. read  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module DPRAM_BE #(
    parameter int width_a  = 32,
    parameter int width_b  = 32,
    parameter int numwords = 256,
    parameter int widthad  = 8
) (
    input  logic                   clock,
    input  logic                   wren,
    input  logic [widthad-1:0]     wraddress,
    input  logic [width_a/8-1:0]   byteena_a,
    input  logic [width_a-1:0]     data,
    input  logic [widthad-1:0]     rdaddress,
    output logic [width_b-1:0]     q
);

    logic [width_a-1:0] mem [numwords];

    // Read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clock) begin
        if (wren) begin
            for (int i = 0; i < width_a/8; i++) begin
                if (byteena_a[i]) begin
                    mem[wraddress][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
        q <= width_b'(mem[rdaddress]);
    end

endmodule
`default_nettype wire

// File: rtl/dpram_be_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_arb2: two-requester round-robin grant with priority pointer |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // Pointer moves to the loser, so it equals grant[0] after any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_be_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dpram_be_arbiter: clears a BE DPRAM, then arbitrates 2W + 1R   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module dpram_be_arbiter
    import dpram_be_arbiter_pkg::*;
#(
    parameter int NUMWORDS = 256,
    parameter int WIDTHAD  = 8,
    parameter int WIDTH    = 32
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 wr0_valid,
    output logic                 wr0_ready,
    input  logic [WIDTHAD-1:0]   wr0_addr,
    input  logic [WIDTH/8-1:0]   wr0_be,
    input  logic [WIDTH-1:0]     wr0_data,
    input  logic                 wr1_valid,
    output logic                 wr1_ready,
    input  logic [WIDTHAD-1:0]   wr1_addr,
    input  logic [WIDTH/8-1:0]   wr1_be,
    input  logic [WIDTH-1:0]     wr1_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [WIDTHAD-1:0]   rd_addr,
    output logic                 rdresp_valid,
    output logic [WIDTH-1:0]     rdresp_data,
    output logic                 init_done
);

    localparam logic [WIDTHAD-1:0] LAST_ADDR = WIDTHAD'(NUMWORDS - 1);

    arb_state_e           state, state_nx;
    logic [WIDTHAD-1:0]   clr_cnt, clr_cnt_nx;
    logic                 run;
    logic [1:0]           grant;
    logic                 ram_we;
    logic [WIDTHAD-1:0]   ram_waddr;
    logic [WIDTH/8-1:0]   ram_be;
    logic [WIDTH-1:0]     ram_wdata;
    logic [WIDTH-1:0]     ram_q;

    assign run = (state == ST_RUN);

    rr_arb2 u_arb (
        .clk   (clock_in),
        .rst   (reset_in),
        .en    (run),
        .req   ({wr1_valid, wr0_valid}),
        .grant (grant)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        if (state == ST_INIT) begin
            clr_cnt_nx = clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
                state_nx = ST_RUN;
            end
        end
    end

    // Clear writes own the port during INIT; afterwards the granted requester does.
    always_comb begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        ram_be    = '1;
        ram_wdata = '0;
        if (run) begin
            ram_we = |grant;
            if (grant[1]) begin
                ram_waddr = wr1_addr;
                ram_be    = wr1_be;
                ram_wdata = wr1_data;
            end else begin
                ram_waddr = wr0_addr;
                ram_be    = wr0_be;
                ram_wdata = wr0_data;
            end
        end
    end

    assign wr0_ready = grant[0];
    assign wr1_ready = grant[1];
    assign rd_ready  = run & ~((|grant) & (ram_waddr == rd_addr));
    assign init_done = run;

    DPRAM_BE #(
        .width_a  (WIDTH),
        .width_b  (WIDTH),
        .numwords (NUMWORDS),
        .widthad  (WIDTHAD)
    ) u_ram (
        .clock     (clock_in),
        .wren      (ram_we),
        .wraddress (ram_waddr),
        .byteena_a (ram_be),
        .data      (ram_wdata),
        .rdaddress (rd_addr),
        .q         (ram_q)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rdresp_valid <= 1'b0;
        end else begin
            rdresp_valid <= rd_valid & rd_ready;
        end
    end

    assign rdresp_data = rdresp_valid ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dpram_be_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------+
// | tb_dpram_be_arbiter: vector table plus read-response scoreboard|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_dpram_be_arbiter;

    localparam int NW = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          wr0_valid = 1'b0, wr1_valid = 1'b0, rd_valid = 1'b0;
    logic          wr0_ready, wr1_ready, rd_ready;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, rd_addr = '0;
    logic [3:0]    wr0_be = '0, wr1_be = '0;
    logic [DW-1:0] wr0_data = '0, wr1_data = '0;
    logic          rdresp_valid, init_done;
    logic [DW-1:0] rdresp_data;

    dpram_be_arbiter #(.NUMWORDS(NW), .WIDTHAD(AW), .WIDTH(DW)) dut (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .wr0_valid    (wr0_valid),
        .wr0_ready    (wr0_ready),
        .wr0_addr     (wr0_addr),
        .wr0_be       (wr0_be),
        .wr0_data     (wr0_data),
        .wr1_valid    (wr1_valid),
        .wr1_ready    (wr1_ready),
        .wr1_addr     (wr1_addr),
        .wr1_be       (wr1_be),
        .wr1_data     (wr1_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rdresp_valid (rdresp_valid),
        .rdresp_data  (rdresp_data),
        .init_done    (init_done)
    );

    always #5 clock_in = ~clock_in;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] model [NW];
    logic [DW-1:0] exp_q [$];
    logic          pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Scoreboard: expected read data is queued at the handshake, popped one cycle later.
    always @(negedge clock_in) begin
        if (reset_in) begin
            exp_q.delete();
            pend = 1'b0;
            for (int i = 0; i < NW; i++) model[i] = '0;
        end else begin
            if (pend) begin
                chk("rdresp_valid", {31'b0, rdresp_valid}, 32'd1);
                if (exp_q.size() > 0) chk("rdresp_data", rdresp_data, exp_q.pop_front());
            end else begin
                chk("rdresp_idle_valid", {31'b0, rdresp_valid}, 32'd0);
                chk("rdresp_idle_data", rdresp_data, 32'd0);
            end
            pend = rd_valid && rd_ready;
            if (pend) exp_q.push_back(model[rd_addr]);
            if (wr0_valid && wr0_ready) model[wr0_addr] = merge(model[wr0_addr], wr0_data, wr0_be);
            if (wr1_valid && wr1_ready) model[wr1_addr] = merge(model[wr1_addr], wr1_data, wr1_be);
        end
    end

    typedef struct {
        logic          w0v, w1v;
        logic [AW-1:0] a0, a1;
        logic [3:0]    be0, be1;
        logic [DW-1:0] d0, d1;
        logic          rv;
        logic [AW-1:0] ra;
        logic          e0, e1, er;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0;
    endtask

    // Entered in cycle 0 after reset release; leaves one cycle after init_done rises.
    task automatic init_seq();
        wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1;
        wr0_addr = 4'd2; wr1_addr = 4'd4; rd_addr = 4'd6;
        for (int k = 0; k <= NW; k++) begin
            @(negedge clock_in);
            chk("init_done_timing", {31'b0, init_done}, (k >= NW) ? 32'd1 : 32'd0);
            if (k < NW) begin
                chk("ready_in_init", {29'b0, wr0_ready, wr1_ready, rd_ready}, 32'd0);
                chk("rdresp_in_init", {31'b0, rdresp_valid}, 32'd0);
            end
            step();
            if (k == NW - 1) idle_inputs();
        end
    endtask

    task automatic read_stream(input int n);
        int streak, best;
        streak = 0;
        best = 0;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                rd_valid = 1'b1;
                rd_addr = AW'(i);
            end else begin
                rd_valid = 1'b0;
            end
            @(negedge clock_in);
            if (i < n) chk("stream_rd_ready", {31'b0, rd_ready}, 32'd1);
            streak = rdresp_valid ? streak + 1 : 0;
            if (streak > best) best = streak;
            step();
        end
        chk("stream_resp_run", best, n);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd3,  4'd0,  4'b0101, 4'h0, 32'hAABBCCDD, 32'h0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 4'd0,  4'd8,  4'h0, 4'hF, 32'h0, 32'h11223344, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 4'd9,  4'd10, 4'hF, 4'hF, 32'hA0A00001, 32'hB0B00001, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 4'd9,  4'd10, 4'hF, 4'hF, 32'hA0A00002, 32'hB0B00002, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 4'd9,  4'd10, 4'hF, 4'hF, 32'hA0A00003, 32'hB0B00003, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 4'd9,  4'd10, 4'hF, 4'hF, 32'hA0A00004, 32'hB0B00004, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'd0,  4'd11, 4'h0, 4'hF, 32'h0, 32'h55667788, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 4'd12, 4'd13, 4'hF, 4'hF, 32'hC0C0C0C0, 32'hD0D0D0D0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 4'd5,  4'd0,  4'hF, 4'h0, 32'h12345678, 32'h0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'd0,  4'd6,  4'h0, 4'hC, 32'h0, 32'hCAFEBABE, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 4'd3,  4'd0,  4'h0, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  4'd0,  4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 4'd6,  1'b0, 1'b0, 1'b1};

        // Reset values with every request asserted.
        wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        chk("reset_ready", {29'b0, wr0_ready, wr1_ready, rd_ready}, 32'd0);
        chk("reset_rdresp_valid", {31'b0, rdresp_valid}, 32'd0);
        chk("reset_rdresp_data", rdresp_data, 32'd0);
        chk("reset_init_done", {31'b0, init_done}, 32'd0);
        idle_inputs();

        // Release, then pulse reset mid-INIT.
        step();
        reset_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_in);
            chk("early_init_done", {31'b0, init_done}, 32'd0);
            step();
        end
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        init_seq();
        read_stream(NW);

        // Table-driven arbitration / hazard vectors.
        foreach (vecs[i]) begin
            wr0_valid = vecs[i].w0v; wr0_addr = vecs[i].a0; wr0_be = vecs[i].be0; wr0_data = vecs[i].d0;
            wr1_valid = vecs[i].w1v; wr1_addr = vecs[i].a1; wr1_be = vecs[i].be1; wr1_data = vecs[i].d1;
            rd_valid  = vecs[i].rv;  rd_addr  = vecs[i].ra;
            @(negedge clock_in);
            chk($sformatf("vec%0d_wr0_ready", i), {31'b0, wr0_ready}, {31'b0, vecs[i].e0});
            chk($sformatf("vec%0d_wr1_ready", i), {31'b0, wr1_ready}, {31'b0, vecs[i].e1});
            chk($sformatf("vec%0d_rd_ready", i),  {31'b0, rd_ready},  {31'b0, vecs[i].er});
            step();
        end
        idle_inputs();
        step();

        // Hand-written hazard with explicit constants.
        wr0_valid = 1'b1; wr0_addr = 4'd7; wr0_be = 4'hF; wr0_data = 32'h12345678;
        rd_valid = 1'b1; rd_addr = 4'd7;
        @(negedge clock_in);
        chk("hazard_stall", {31'b0, rd_ready}, 32'd0);
        step();
        wr0_valid = 1'b0;
        @(negedge clock_in);
        chk("hazard_accept", {31'b0, rd_ready}, 32'd1);
        step();
        rd_valid = 1'b0;
        @(negedge clock_in);
        chk("hazard_resp_valid", {31'b0, rdresp_valid}, 32'd1);
        chk("hazard_resp_data", rdresp_data, 32'h12345678);
        step();

        read_stream(8);

        // Reset in RUN with a read being accepted on the reset edge.
        rd_valid = 1'b1; rd_addr = 4'd3; reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        rd_valid = 1'b0;
        init_seq();
        read_stream(NW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
